// File: rtl/tick_pkg.sv
// Shared timer state encoding, default divider/timer widths and named game periods.
// Constants only; no logic, no latency, no backpressure.
package tick_pkg;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    localparam int SEG_DIV_LOG2_DEF = 17;
    localparam int PIX_DIV_LOG2_DEF = 1;
    localparam int TMR_W_DEF        = 26;

    localparam int TMR_BLINK = 25_000_000;
    localparam int TMR_MSG   = 50_000_000;

endpackage

// File: rtl/tick_timer.sv
// Programmable one-shot/periodic timer; expire lands P cycles after the start sample.
// No backpressure: stop beats start, and a nonzero start retriggers a running timer.
module tick_timer
    import tick_pkg::*;
#(
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tmr_start,
    input  logic [TMR_W-1:0] tmr_period,
    input  logic             tmr_periodic,
    input  logic             tmr_stop,
    output logic             tmr_busy,
    output logic             tmr_expire
);

    tmr_state_e       state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] per_q, per_d;
    logic             mode_q, mode_d;
    logic             load;
    logic             at_zero;

    assign load    = tmr_start && (tmr_period != '0);
    assign at_zero = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        mode_d  = mode_q;
        if (tmr_stop) begin
            state_d = TMR_IDLE;
        end else if (load) begin
            // Start from IDLE and retrigger in RUN share one path
            state_d = TMR_RUN;
            cnt_d   = tmr_period - TMR_W'(1);
            per_d   = tmr_period;
            mode_d  = tmr_periodic;
        end else if (state_q == TMR_RUN) begin
            if (!at_zero) begin
                cnt_d = cnt_q - TMR_W'(1);
            end else if (mode_q) begin
                cnt_d = per_q - TMR_W'(1);
            end else begin
                state_d = TMR_IDLE;
            end
        end
    end

    assign tmr_busy   = (state_q == TMR_RUN);
    assign tmr_expire = (state_q == TMR_RUN) && at_zero;

endmodule

// File: rtl/tick_sched.sv
// Clock-enable strobes (pixel, 7-seg scan, digit select) from one free-running counter plus a game timer.
// Strobes decode from registered state; seg_sel follows seg_ce by one cycle; no backpressure.
module tick_sched
    import tick_pkg::*;
#(
    parameter int SEG_DIV_LOG2 = SEG_DIV_LOG2_DEF,
    parameter int PIX_DIV_LOG2 = PIX_DIV_LOG2_DEF,
    parameter int TMR_W        = TMR_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    output logic             pix_ce,
    output logic             seg_ce,
    output logic [1:0]       seg_sel,
    input  logic             tmr_start,
    input  logic [TMR_W-1:0] tmr_period,
    input  logic             tmr_periodic,
    input  logic             tmr_stop,
    output logic             tmr_busy,
    output logic             tmr_expire
);

    logic [SEG_DIV_LOG2-1:0] q_q, q_d;
    logic [1:0]              seg_sel_q, seg_sel_d;

    assign q_d       = q_q + SEG_DIV_LOG2'(1);
    assign seg_sel_d = seg_ce ? seg_sel_q + 2'd1 : seg_sel_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q       <= '0;
            seg_sel_q <= 2'd0;
        end else begin
            q_q       <= q_d;
            seg_sel_q <= seg_sel_d;
        end
    end

    // The pixel period is a power of two, so its strobe is just the low bits all-ones
    assign pix_ce  = &q_q[PIX_DIV_LOG2-1:0];
    assign seg_ce  = &q_q;
    assign seg_sel = seg_sel_q;

    tick_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk         (clk),
        .clr         (clr),
        .tmr_start   (tmr_start),
        .tmr_period  (tmr_period),
        .tmr_periodic(tmr_periodic),
        .tmr_stop    (tmr_stop),
        .tmr_busy    (tmr_busy),
        .tmr_expire  (tmr_expire)
    );

endmodule

// File: doc/tick_sched.md
# tick_sched

Single-clock tick scheduler replacing derived clocks with clock-enable strobes for the game logic, VGA and 7-segment blocks. It generates a pixel-rate enable, a 7-segment scan enable and a 2-bit digit-select index from one free-running counter. It also provides one programmable one-shot/periodic timer for game logic (cursor blink, message hold, round timeout). Every consumer runs on `clk` and qualifies its state updates with these strobes; no logic is clocked by a divided signal.

## Interface
Parameters:
- `SEG_DIV_LOG2`, 17, log2 of the scan-enable period in `clk` cycles (2^17 cycles gives 381.47 Hz at 50 MHz).
- `PIX_DIV_LOG2`, 1, log2 of the pixel-enable period (legal range 1..`SEG_DIV_LOG2`-1).
- `TMR_W`, 26, timer period width in bits.

Ports:
- `clk`  in  1  master clock, 50 MHz.
- `clr`  in  1  reset; one clock; reset is synchronous and active-high.
- `pix_ce`  out  1  one-cycle strobe, once every 2^`PIX_DIV_LOG2` cycles.
- `seg_ce`  out  1  one-cycle strobe, once every 2^`SEG_DIV_LOG2` cycles.
- `seg_sel`  out  2  active 7-segment digit index, advanced by `seg_ce`.
- `tmr_start`  in  1  level-sampled; starts or restarts the timer.
- `tmr_period`  in  `TMR_W`  timer period in cycles; sampled with `tmr_start`.
- `tmr_periodic`  in  1  sampled with `tmr_start`; 1 = auto-reload, 0 = one-shot.
- `tmr_stop`  in  1  cancels the timer.
- `tmr_busy`  out  1  timer is in RUN.
- `tmr_expire`  out  1  one-cycle expiry strobe.

## Operation
- Free-running counter `q[SEG_DIV_LOG2-1:0]`: cleared by `clr`, otherwise increments every cycle and wraps from all-ones to 0.
- `pix_ce` = `q[PIX_DIV_LOG2-1:0]` all-ones. `seg_ce` = `q` all-ones. Both decode from the registered `q`.
- `seg_sel`: register; increments on `seg_ce` (registered, takes effect after that edge); wraps 3→0.
- Timer FSM, states IDLE and RUN. Registers: `cnt[TMR_W]`, `per[TMR_W]`, `per_mode`.
  - IDLE, `tmr_start`=1 and `tmr_period`≠0: load `cnt`←`tmr_period`-1, latch `per` and `per_mode`, go to RUN.
  - IDLE, `tmr_start`=1 and `tmr_period`=0: ignored; stay in IDLE.
  - RUN, `cnt`≠0: decrement `cnt`.
  - RUN, `cnt`=0: if `per_mode`=1, reload `cnt`←`per`-1 and stay in RUN; otherwise go to IDLE.
  - RUN, `tmr_start`=1 with nonzero period: retrigger; reload from the new inputs. Retrigger overrides decrement and reload.
  - Any state, `tmr_stop`=1: go to IDLE. Stop has priority over start.
- `tmr_expire` = (state==RUN && `cnt`==0). It depends on state only, so it still asserts in a cycle where stop or start is applied.
- `tmr_busy` = (state==RUN).

## Timing
- Reset values: `q`=0, `seg_sel`=0, state=IDLE, `cnt`=0, `per`=0, `per_mode`=0. Consequently `pix_ce`=0, `seg_ce`=0, `tmr_busy`=0 and `tmr_expire`=0.
- First strobes after `clr` falls (cycle 0 has `q`=0):
  - `pix_ce` in cycle 2^`PIX_DIV_LOG2`-1, then every 2^`PIX_DIV_LOG2` cycles.
  - `seg_ce` in cycle 2^`SEG_DIV_LOG2`-1, then every 2^`SEG_DIV_LOG2` cycles.
- `seg_sel` changes in the cycle after `seg_ce`.
- Timer latency: `tmr_start` sampled in cycle t with period P gives `tmr_busy`=1 from t+1 and `tmr_expire` in cycle t+P. For P=1 that is t+1.
- Periodic mode: `tmr_expire` at t+P, t+2P, …, with `tmr_busy` continuously 1.
- One-shot mode: `tmr_busy` falls in cycle t+P+1.
- Stop sampled in cycle s: `tmr_busy`=0 from s+1. No later expire.
- `clr` during RUN: IDLE on the next cycle. No expire is generated.
- Maximum period 2^`TMR_W`-1 cycles (≈1.34 s at 50 MHz).

## Structure
- Shared package `tick_pkg`:
  - timer state encoding (IDLE=1'b0, RUN=1'b1);
  - default `SEG_DIV_LOG2`, `PIX_DIV_LOG2`, `TMR_W`;
  - named period constants `TMR_BLINK`=25_000_000 and `TMR_MSG`=50_000_000.
- Sub-module `tick_timer` holds the timer FSM, `cnt`, `per` and `per_mode`. The top level holds `q`, the strobe decode and `seg_sel`.

## Test plan
- Reset, then 16 cycles with `PIX_DIV_LOG2`=1 → `pix_ce` high in cycles 1,3,5,…; all outputs 0 during `clr`.
- `SEG_DIV_LOG2`=4 → `seg_ce` in cycles 15,31,47,63; `seg_sel` sequence 0,1,2,3,0, each value changing one cycle after `seg_ce`.
- One-shot start, P=5, at cycle 10 → `tmr_expire` only in cycle 15; `tmr_busy` 11..15; P=1 → expire in cycle 11.
- Periodic start, P=3, at cycle 0 → expires at 3,6,9,12; stop at cycle 10 → `tmr_busy`=0 from 11; no expire at 12.
- Retrigger with P=4 in cycle 2 of a P=5 run started at 0 → expire at 6, not 5. Start with P=0 in IDLE → stays IDLE.
- Start and stop in the same cycle → IDLE. `clr` asserted mid-RUN → IDLE next cycle, no expire.
